// File: rtl/uart_sender_arbiter_pkg.sv
// Shared types for the UART sender arbiter.
//   matrix_element_t : one matrix cell value as handed to the element sender
//   sender_job_t     : one captured sender job (value + formatting flags)
//   arb_state_t      : arbiter FSM states
package uart_sender_arbiter_pkg;

    localparam int ELEM_W       = 8;
    localparam int SENDER_REQ_N = 3;   // echo, display, calc result

    typedef logic [ELEM_W-1:0] matrix_element_t;

    typedef struct packed {
        matrix_element_t data;
        logic            last_col;
        logic            nl_only;
        logic            id;
    } sender_job_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_HOLD  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_sender_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   pending : request vector, one bit per requester
//   ptr     : index of the last granted requester
//   winner  : first pending index strictly after ptr, wrapping (ptr itself last)
//   valid   : any request pending
module uart_sender_arbiter_rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    int idx;

    // Scan from farthest to nearest so the nearest pending slot after ptr
    // is the last one written and therefore wins.
    always_comb begin
        winner = ptr;
        valid  = |pending;
        idx    = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (pending[idx[IDX_W-1:0]])
                winner = idx[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/uart_sender_arbiter.sv
// Round-robin arbiter sharing one UART element sender between N_REQ requesters.
// Each requester's start pulse and fields are captured into a slot; one job at
// a time is forwarded to the sender and a done pulse is returned to its owner.
// An owner holding req_lock keeps the sender between jobs (uninterleaved dump).
//   req_*  : per-requester start pulse, job fields, lock level; req_done pulse back
//   snd_*  : job to the sender (start pulse + fields held for the whole job), snd_done back
//   grant_idx : current/last owner, busy : FSM not idle, ovf_err : sticky start-while-pending
module uart_sender_arbiter
    import uart_sender_arbiter_pkg::*;
#(
    parameter int N_REQ = SENDER_REQ_N,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic            [N_REQ-1:0]        req_start,
    input  matrix_element_t [N_REQ-1:0]        req_data,
    input  logic            [N_REQ-1:0]        req_is_last_col,
    input  logic            [N_REQ-1:0]        req_newline_only,
    input  logic            [N_REQ-1:0]        req_id,
    input  logic            [N_REQ-1:0]        req_lock,
    output logic            [N_REQ-1:0]        req_done,
    output logic                               snd_start,
    output matrix_element_t                    snd_data,
    output logic                               snd_is_last_col,
    output logic                               snd_newline_only,
    output logic                               snd_id,
    input  logic                               snd_done,
    output logic            [IDX_W-1:0]        grant_idx,
    output logic                               busy,
    output logic                               ovf_err
);

    arb_state_t       state;
    logic [N_REQ-1:0] pending;
    logic [IDX_W-1:0] rr_ptr;
    sender_job_t      slot [N_REQ];
    sender_job_t      snd_job;   // held between jobs so snd_* never glitch to 0
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    uart_sender_arbiter_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .pending (pending),
        .ptr     (rr_ptr),
        .winner  (pick_idx),
        .valid   (pick_valid)
    );

    assign snd_data         = snd_job.data;
    assign snd_is_last_col  = snd_job.last_col;
    assign snd_newline_only = snd_job.nl_only;
    assign snd_id           = snd_job.id;
    assign busy             = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pending   <= '0;
            rr_ptr    <= '0;
            grant_idx <= '0;
            snd_start <= 1'b0;
            snd_job   <= '0;
            req_done  <= '0;
            ovf_err   <= 1'b0;
            for (int i = 0; i < N_REQ; i++)
                slot[i] <= '0;
        end else begin
            req_done <= '0;

            // Capture runs in every state; a second start on a busy slot is dropped.
            for (int i = 0; i < N_REQ; i++) begin
                if (req_start[i]) begin
                    if (pending[i]) begin
                        ovf_err <= 1'b1;
                    end else begin
                        pending[i] <= 1'b1;
                        slot[i]    <= '{data:     req_data[i],
                                        last_col: req_is_last_col[i],
                                        nl_only:  req_newline_only[i],
                                        id:       req_id[i]};
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_idx <= pick_idx;
                        snd_job   <= slot[pick_idx];
                        snd_start <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // pending is still set here, so a same-slot start this cycle overflows
                    snd_start          <= 1'b0;
                    pending[grant_idx] <= 1'b0;
                    state              <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (snd_done) begin
                        req_done[grant_idx] <= 1'b1;
                        if (req_lock[grant_idx]) begin
                            state <= ST_HOLD;
                        end else begin
                            rr_ptr <= grant_idx;
                            state  <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    // Owner is served again without rearbitration.
                    if (pending[grant_idx]) begin
                        snd_job   <= slot[grant_idx];
                        snd_start <= 1'b1;
                        state     <= ST_ISSUE;
                    end else if (!req_lock[grant_idx]) begin
                        rr_ptr <= grant_idx;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_sender_arbiter.sv
// Self-checking bench for uart_sender_arbiter: a per-cycle vector table for
// single-job and round-robin traffic, plus hand-written lock, overflow and
// mid-job reset sequences.
module tb_uart_sender_arbiter;
    import uart_sender_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int IW = 2;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic            [N-1:0]    req_start = '0;
    matrix_element_t [N-1:0]    req_data;
    logic            [N-1:0]    req_is_last_col;
    logic            [N-1:0]    req_newline_only;
    logic            [N-1:0]    req_id;
    logic            [N-1:0]    req_lock = '0;
    logic            [N-1:0]    req_done;
    logic                       snd_start;
    matrix_element_t            snd_data;
    logic                       snd_is_last_col;
    logic                       snd_newline_only;
    logic                       snd_id;
    logic                       snd_done = 1'b0;
    logic            [IW-1:0]   grant_idx;
    logic                       busy;
    logic                       ovf_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uart_sender_arbiter #(.N_REQ(N), .IDX_W(IW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_start        (req_start),
        .req_data         (req_data),
        .req_is_last_col  (req_is_last_col),
        .req_newline_only (req_newline_only),
        .req_id           (req_id),
        .req_lock         (req_lock),
        .req_done         (req_done),
        .snd_start        (snd_start),
        .snd_data         (snd_data),
        .snd_is_last_col  (snd_is_last_col),
        .snd_newline_only (snd_newline_only),
        .snd_id           (snd_id),
        .snd_done         (snd_done),
        .grant_idx        (grant_idx),
        .busy             (busy),
        .ovf_err          (ovf_err)
    );

    typedef struct {
        logic [N-1:0]    start;
        logic            sdone;
        logic            exp_sstart;
        logic [IW-1:0]   exp_gidx;
        logic [N-1:0]    exp_rdone;
        logic            exp_busy;
        matrix_element_t exp_sdata;
    } vec_t;

    vec_t vecs [26];

    function automatic vec_t mk(input logic [N-1:0] st, input logic sd, input logic ss,
                                input logic [IW-1:0] g, input logic [N-1:0] rd,
                                input logic b, input matrix_element_t d);
        vec_t v;
        v.start = st; v.sdone = sd; v.exp_sstart = ss; v.exp_gidx = g;
        v.exp_rdone = rd; v.exp_busy = b; v.exp_sdata = d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fixed per-slot job contents: slot0=5, slot1=0x21, slot2=0x32.
        req_data[0] = 8'h05; req_data[1] = 8'h21; req_data[2] = 8'h32;
        req_is_last_col  = 3'b100;
        req_newline_only = 3'b010;
        req_id           = 3'b001;

        // Single job on req0, then three-way round robin twice with a stray
        // snd_done in IDLE in between. rr pointer is 0 after the first job, so
        // each batch is served 1,2,0.
        //               start  sd ss g  rdone  b  sdata
        vecs[0]  = mk(3'b001, 0, 0, 0, 3'b000, 0, 8'h00);
        vecs[1]  = mk(3'b000, 0, 1, 0, 3'b000, 1, 8'h05);
        vecs[2]  = mk(3'b000, 0, 0, 0, 3'b000, 1, 8'h05);
        vecs[3]  = mk(3'b000, 1, 0, 0, 3'b001, 0, 8'h05);
        vecs[4]  = mk(3'b000, 0, 0, 0, 3'b000, 0, 8'h05);
        vecs[5]  = mk(3'b111, 0, 0, 0, 3'b000, 0, 8'h05);
        vecs[6]  = mk(3'b000, 0, 1, 1, 3'b000, 1, 8'h21);
        vecs[7]  = mk(3'b000, 0, 0, 1, 3'b000, 1, 8'h21);
        vecs[8]  = mk(3'b000, 1, 0, 1, 3'b010, 0, 8'h21);
        vecs[9]  = mk(3'b000, 0, 1, 2, 3'b000, 1, 8'h32);
        vecs[10] = mk(3'b000, 0, 0, 2, 3'b000, 1, 8'h32);
        vecs[11] = mk(3'b000, 1, 0, 2, 3'b100, 0, 8'h32);
        vecs[12] = mk(3'b000, 0, 1, 0, 3'b000, 1, 8'h05);
        vecs[13] = mk(3'b000, 0, 0, 0, 3'b000, 1, 8'h05);
        vecs[14] = mk(3'b000, 1, 0, 0, 3'b001, 0, 8'h05);
        vecs[15] = mk(3'b000, 1, 0, 0, 3'b000, 0, 8'h05);
        vecs[16] = mk(3'b111, 0, 0, 0, 3'b000, 0, 8'h05);
        vecs[17] = mk(3'b000, 0, 1, 1, 3'b000, 1, 8'h21);
        vecs[18] = mk(3'b000, 0, 0, 1, 3'b000, 1, 8'h21);
        vecs[19] = mk(3'b000, 1, 0, 1, 3'b010, 0, 8'h21);
        vecs[20] = mk(3'b000, 0, 1, 2, 3'b000, 1, 8'h32);
        vecs[21] = mk(3'b000, 0, 0, 2, 3'b000, 1, 8'h32);
        vecs[22] = mk(3'b000, 1, 0, 2, 3'b100, 0, 8'h32);
        vecs[23] = mk(3'b000, 0, 1, 0, 3'b000, 1, 8'h05);
        vecs[24] = mk(3'b000, 0, 0, 0, 3'b000, 1, 8'h05);
        vecs[25] = mk(3'b000, 1, 0, 0, 3'b001, 0, 8'h05);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {snd_start, snd_data, snd_is_last_col, snd_newline_only, snd_id,
                           grant_idx, busy, ovf_err, req_done}, '0);
        rst_n = 1'b1;
        tick();

        // Vector table
        for (int i = 0; i < 26; i++) begin
            req_start = vecs[i].start;
            snd_done  = vecs[i].sdone;
            tick();
            req_start = '0;
            snd_done  = 1'b0;
            chk($sformatf("vec%0d", i),
                {snd_start, grant_idx, req_done, busy, snd_data},
                {vecs[i].exp_sstart, vecs[i].exp_gidx, vecs[i].exp_rdone,
                 vecs[i].exp_busy, vecs[i].exp_sdata});
            if (vecs[i].exp_sstart)
                chk($sformatf("vec%0d_flags", i),
                    {snd_is_last_col, snd_newline_only, snd_id},
                    {req_is_last_col[vecs[i].exp_gidx], req_newline_only[vecs[i].exp_gidx],
                     req_id[vecs[i].exp_gidx]});
        end
        chk("no_ovf_table", ovf_err, 1'b0);

        // Lock: req1 runs 4 jobs under lock, req0 starts during job 1 and is
        // served only after the lock drops.
        tick();
        req_start = 3'b010; req_lock = 3'b010;
        tick();
        req_start = '0;
        tick();
        chk("lock_issue0", {snd_start, grant_idx, snd_data}, {1'b1, 2'd1, 8'h21});
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("lock_busy%0d", j), {snd_start, busy}, 2'b01);
            snd_done = 1'b1;
            if (j < 3)  req_start[1] = 1'b1;
            if (j == 1) req_start[0] = 1'b1;
            tick();
            snd_done = 1'b0; req_start = '0;
            chk($sformatf("lock_done%0d", j), {req_done, busy}, {3'b010, 1'b1});
            if (j < 3) begin
                tick();
                chk($sformatf("lock_reissue%0d", j + 1), {snd_start, grant_idx}, {1'b1, 2'd1});
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("lock_hold%0d", k), {snd_start, busy, grant_idx}, {1'b0, 1'b1, 2'd1});
        end
        req_lock = '0;
        tick();
        chk("lock_release", busy, 1'b0);
        tick();
        chk("lock_then_req0", {snd_start, grant_idx, snd_data}, {1'b1, 2'd0, 8'h05});
        tick();
        snd_done = 1'b1;
        tick();
        snd_done = 1'b0;
        chk("lock_req0_done", req_done, 3'b001);
        tick();

        // Overflow: req2 starts twice back to back; second start (different
        // data) is dropped and flags ovf_err.
        req_start = 3'b100;
        tick();
        req_data[2] = 8'h77;
        tick();
        req_start = '0; req_data[2] = 8'h32;
        chk("ovf_set", ovf_err, 1'b1);
        chk("ovf_issue", {snd_start, grant_idx, snd_data}, {1'b1, 2'd2, 8'h32});
        tick();
        snd_done = 1'b1;
        tick();
        snd_done = 1'b0;
        chk("ovf_done", req_done, 3'b100);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("ovf_no_second%0d", k), {snd_start, busy}, 2'b00);
        end
        chk("ovf_sticky", ovf_err, 1'b1);

        // Reset mid-job: job dropped, no req_done, later job served normally.
        req_start = 3'b001;
        tick();
        req_start = '0;
        tick();
        tick();
        chk("rst_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", {snd_start, snd_data, snd_is_last_col, snd_newline_only, snd_id,
                               grant_idx, busy, ovf_err, req_done}, '0);
        snd_done = 1'b1;
        tick();
        snd_done = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_no_done", {req_done, busy}, 4'b0000);
        req_start = 3'b010;
        tick();
        req_start = '0;
        tick();
        chk("rst_new_issue", {snd_start, grant_idx, snd_data, snd_is_last_col, snd_newline_only, snd_id},
            {1'b1, 2'd1, 8'h21, 1'b0, 1'b1, 1'b0});
        tick();
        snd_done = 1'b1;
        tick();
        snd_done = 1'b0;
        chk("rst_new_done", req_done, 3'b010);
        tick();
        chk("rst_new_idle", {req_done, busy}, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
